fifo_sync_ctrl: RTL and testbench



---
 rtl/fifo_sync_ctrl.sv | 90 +++++++++
 tb/tb_fifo_sync_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO pointer/flag controller: drives the memory write enable and
// addresses, and derives full/empty/almost flags, occupancy and sticky errors.
module fifo_sync_ctrl #(
    parameter int ADDRSIZE   = 4,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic                rinc,
    input  logic                clr_err,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                wfull,
    output logic                rempty,
    output logic                walmost_full,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [ADDRSIZE:0] PTR_ONE    = (ADDRSIZE+1)'(1);
    localparam logic [ADDRSIZE:0] AFULL_CNT  = (ADDRSIZE+1)'(AFULL_LVL);
    localparam logic [ADDRSIZE:0] AEMPTY_CNT = (ADDRSIZE+1)'(AEMPTY_LVL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDRSIZE:0] r_wptr;
    logic [ADDRSIZE:0] r_rptr;
    logic              r_overflow;
    logic              r_underflow;

    logic [ADDRSIZE:0] w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_ok;
    logic              w_rd_ok;

    // NOTE: every signal is assigned on every pass through this block, so no
    // latch can be inferred.
    always_comb begin
        w_count = r_wptr - r_rptr;
        w_empty = (r_wptr == r_rptr);
        w_full  = (r_wptr[ADDRSIZE] != r_rptr[ADDRSIZE]) &&
                  (r_wptr[ADDRSIZE-1:0] == r_rptr[ADDRSIZE-1:0]);
        w_wr_ok = winc & ~w_full;
        w_rd_ok = rinc & ~w_empty;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what makes the simultaneous push/pop
    // rules fall out naturally.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + PTR_ONE;
            if (w_rd_ok) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // A new error in the same cycle as clr_err stays set.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && w_full)    r_overflow <= 1'b1;
            else if (clr_err)      r_overflow <= 1'b0;

            if (rinc && w_empty)   r_underflow <= 1'b1;
            else if (clr_err)      r_underflow <= 1'b0;
        end
    end

    assign wclken        = w_wr_ok;
    assign waddr         = r_wptr[ADDRSIZE-1:0];
    assign raddr         = r_rptr[ADDRSIZE-1:0];
    assign wfull         = w_full;
    assign rempty        = w_empty;
    assign count         = w_count;
    assign walmost_full  = (w_count >= AFULL_CNT);
    assign ralmost_empty = (w_count <= AEMPTY_CNT);
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Self-checking bench for fifo_sync_ctrl: a queue-based FIFO model plus a small
// memory array exercise fill, drain, simultaneous access, wrap and error handling.
module tb_fifo_sync_ctrl;

    localparam int ADDRSIZE = 4;
    localparam int DEPTH    = 16;
    localparam int AF_LVL   = 12;
    localparam int AE_LVL   = 2;

    logic wclk, wrst, winc, rinc, clr_err;
    logic wclken, wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
    logic [ADDRSIZE-1:0] waddr, raddr;
    logic [ADDRSIZE:0]   count;
    logic [7:0]          wdata;
    logic [7:0]          mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents queue, accepted-transfer totals, sticky errors.
    logic [7:0] q[$];
    int         wtot, rtot;
    bit         m_ovf, m_udf;

    bit         obs_wclken, exp_wclken, popped;
    logic [7:0] got_d, exp_d;

    fifo_sync_ctrl #(
        .ADDRSIZE  (ADDRSIZE),
        .AFULL_LVL (AF_LVL),
        .AEMPTY_LVL(AE_LVL)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .rinc         (rinc),
        .clr_err      (clr_err),
        .wclken       (wclken),
        .waddr        (waddr),
        .raddr        (raddr),
        .wfull        (wfull),
        .rempty       (rempty),
        .walmost_full (walmost_full),
        .ralmost_empty(ralmost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    always @(posedge wclk) if (wclken) mem[waddr] <= wdata;

    function automatic logic [18:0] dut_vec();
        return {count, waddr, raddr, wfull, rempty, walmost_full, ralmost_empty,
                overflow, underflow};
    endfunction

    function automatic logic [18:0] model_vec();
        int sz;
        sz = q.size();
        return {5'(sz), 4'(wtot), 4'(rtot), sz == DEPTH, sz == 0, sz >= AF_LVL,
                sz <= AE_LVL, m_ovf, m_udf};
    endfunction

    // Drives one cycle, samples combinational outputs before the edge and
    // advances the model from the pre-edge state.
    task automatic cycle(input bit w, input bit r, input bit c, input bit rst,
                         input logic [7:0] d);
        int sz;
        bit wr, rd;
        winc = w; rinc = r; clr_err = c; wrst = rst; wdata = d;
        #1;
        sz         = q.size();
        wr         = w && (sz != DEPTH);
        rd         = r && (sz != 0);
        obs_wclken = wclken;
        exp_wclken = wr;
        popped     = rd && !rst;
        if (popped) begin
            got_d = mem[raddr];
            exp_d = q[0];
        end
        @(posedge wclk);
        if (rst) begin
            q.delete();
            wtot = 0; rtot = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (rd) begin void'(q.pop_front()); rtot++; end
            if (wr) begin q.push_back(d); wtot++; end
            if (w && sz == DEPTH) m_ovf = 1; else if (c) m_ovf = 0;
            if (r && sz == 0)     m_udf = 1; else if (c) m_udf = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 1, 8'h11);
        cycle(1, 0, 0, 1, 8'h22);
        winc = 1'b1; rinc = 1'b0; wrst = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== 19'b00000_0000_0000_0_1_0_1_0_0) begin
            n_errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), 19'b00000_0000_0000_0_1_0_1_0_0);
        end
        n_checks++;
        if (wclken !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_wclken got=%b exp=1", wclken);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 0, 0, 8'(i));
            n_checks++;
            if (obs_wclken !== 1'b1) begin
                n_errors++;
                $display("FAIL fill_wclken[%0d] got=%b exp=1", i, obs_wclken);
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL fill_state[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        cycle(1, 0, 0, 0, 8'hEE);
        n_checks++;
        if (obs_wclken !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_extra_wclken got=%b exp=0", obs_wclken);
        end
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_errors++;
            $display("FAIL fill_extra_state got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 0, 0, 8'h00);
            n_checks++;
            if (!popped || got_d !== 8'(i)) begin
                n_errors++;
                $display("FAIL drain_data[%0d] got=%h exp=%h", i, got_d, 8'(i));
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL drain_state[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        cycle(0, 1, 0, 0, 8'h00);
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_errors++;
            $display("FAIL drain_extra_state got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_simultaneous();
        int fills [3] = '{DEPTH, 0, 5};
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, 8'h00);
            for (int i = 0; i < fills[k]; i++) cycle(1, 0, 0, 0, 8'(8'h40 + i));
            cycle(1, 1, 0, 0, 8'h99);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL simul_state[occ=%0d] got=%h exp=%h", fills[k], dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom), 1'($urandom), 1'b0, 1'b0, 8'($urandom));
            if (popped) begin
                n_checks++;
                if (got_d !== exp_d) begin
                    n_errors++;
                    $display("FAIL wrap_data[%0d] got=%h exp=%h", i, got_d, exp_d);
                end
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL wrap_state[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_err_clear();
        cycle(0, 0, 0, 1, 8'h00);
        for (int i = 0; i <= DEPTH; i++) cycle(1, 0, 0, 0, 8'(i));
        cycle(0, 0, 1, 0, 8'h00);
        n_checks++;
        if (overflow !== 1'b0 || dut_vec() !== model_vec()) begin
            n_errors++;
            $display("FAIL err_clear_ovf got=%h exp=%h", dut_vec(), model_vec());
        end
        cycle(1, 0, 1, 0, 8'h00);
        n_checks++;
        if (overflow !== 1'b1 || dut_vec() !== model_vec()) begin
            n_errors++;
            $display("FAIL err_set_wins got=%h exp=%h", dut_vec(), model_vec());
        end
        for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 8'h00);
        n_checks++;
        if (count !== 5'd7) begin
            n_errors++;
            $display("FAIL err_count7 got=%0d exp=7", count);
        end
        cycle(1, 1, 0, 1, 8'h00);
        n_checks++;
        if (count !== 5'd0 || rempty !== 1'b1 || dut_vec() !== model_vec()) begin
            n_errors++;
            $display("FAIL midop_reset got=%h exp=%h", dut_vec(), model_vec());
        end
        cycle(0, 1, 0, 0, 8'h00);
        cycle(0, 1, 1, 0, 8'h00);
        n_checks++;
        if (underflow !== 1'b1) begin
            n_errors++;
            $display("FAIL udf_set_wins got=%b exp=1", underflow);
        end
        cycle(0, 0, 1, 0, 8'h00);
        n_checks++;
        if (underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL udf_clear got=%b exp=0", underflow);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom), 1'($urandom), ($urandom % 8) == 0,
                  ($urandom % 64) == 0, 8'($urandom));
            n_checks++;
            if (obs_wclken !== exp_wclken) begin
                n_errors++;
                $display("FAIL rand_wclken[%0d] got=%b exp=%b", i, obs_wclken, exp_wclken);
            end
            if (popped) begin
                n_checks++;
                if (got_d !== exp_d) begin
                    n_errors++;
                    $display("FAIL rand_data[%0d] got=%h exp=%h", i, got_d, exp_d);
                end
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL rand_state[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        wrst = 1'b1; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = 8'h00;
        wtot = 0; rtot = 0; m_ovf = 0; m_udf = 0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_err_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
